sync_fifo_flex: RTL and testbench
=================================

// Module: sync_fifo_flex
// PURPOSE
//   Parametrised single-clock FIFO, successor to the basic sync FIFO.
//   Supports any DEPTH >= 2, including non-power-of-2, and simultaneous read/write.
//   Read mode is selectable: registered or first-word-fall-through (FWFT).
//   Provides fill count, programmable almost-full/almost-empty, sticky overflow/underflow flags and a synchronous flush.
//   Used as the general buffering element between producer/consumer stages in one clock domain.
// PARAMETERS
//   WIDTH      8  data word width in bits (>= 1)
//   DEPTH      8  number of storage entries (>= 2, any integer)
//   FWFT       0  0 = registered read (1-cycle latency); 1 = first-word-fall-through
//   AF_THRESH  6  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  1  almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//   clk           in   1                     clock, rising edge
//   rst_n         in   1                     asynchronous, active-low reset
//   flush         in   1                     synchronous clear of contents and flags
//   write         in   1                     write request
//   data_in       in   WIDTH                 write data
//   read          in   1                     read request (FWFT: pop/acknowledge)
//   data_out      out  WIDTH                 read data
//   rd_valid      out  1                     data_out holds a valid popped/head word
//   full          out  1                     count == DEPTH
//   empty         out  1                     count == 0
//   almost_full   out  1                     count >= AF_THRESH
//   almost_empty  out  1                     count <= AE_THRESH
//   count         out  $clog2(DEPTH+1)       current number of stored words
//   overflow      out  1                     sticky: write attempted while full
//   underflow     out  1                     sticky: read attempted while empty
// BEHAVIOUR
//   - Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
//   - Reset (rst_n=0, async): head=tail=count=0, data_out=0, rd_valid=0, overflow=underflow=0.
//     Storage contents are not reset.
//   - Reset state of flags: empty=1, full=0; almost_empty=1, almost_full=(AF_THRESH==0).
//   - Acceptance: wr_ok = write & !full; rd_ok = read & !empty.
//     Both are evaluated on pre-edge state.
//   - Full + write + read: the read is accepted and the write is rejected (overflow set).
//   - Empty + write + read: the write is accepted and the read is rejected (underflow set).
//   - Write path: wr_ok stores data_in at mem[head]; head advances to head+1, or 0 when head==DEPTH-1.
//     Wrap uses an explicit compare, never a power-of-2 truncation.
//   - Read path: rd_ok advances tail with the same wrap rule.
//   - count update: count_next = count + wr_ok - rd_ok; unchanged when both are accepted.
//     All status flags are registered from count_next, so they are valid in the cycle after the edge.
//   - FWFT=0: on rd_ok, data_out <= mem[tail] and rd_valid=1 for exactly the next cycle.
//     Otherwise rd_valid=0 and data_out holds its last value. Read latency is 1 cycle.
//   - FWFT=1: data_out = mem[tail] combinationally; rd_valid = !empty.
//     read pops the displayed word. A word written into an empty FIFO appears 1 cycle after the write edge.
//   - overflow: set on write & full; underflow: set on read & empty.
//     Both stay set until flush or reset. Rejected operations change no other state.
//   - flush=1 (sync): head=tail=count=0, rd_valid=0, overflow=underflow=0, data_out=0.
//     flush takes priority over write/read in the same cycle, and those requests are discarded.
//   - Reset mid-operation: all state returns immediately to reset values. No partial write is retained.
// TESTING
//   - Basic order, DEPTH=6, FWFT=0: write 0x11..0x16 on 6 consecutive cycles.
//     Required: full=1 and count=6 after the 6th edge.
//     Then 6 reads return 0x11..0x16 in order, each 1 cycle after its read, with rd_valid pulses.
//     Finally empty=1.
//   - Wrap-around, DEPTH=6: run 20 interleaved write/read ops so the pointers wrap at 5->0 three times.
//     Required: data order preserved, count tracks a scoreboard exactly.
//   - Simultaneous ops at count=3: write+read together for 10 cycles.
//     Required: count stays 3, and the outputs equal the input delayed by 3 entries.
//   - Simultaneous ops when full: write+read.
//     Required: one word popped, count=5, overflow=1, and the pushed word is absent.
//   - Simultaneous ops when empty: write+read.
//     Required: count=1, underflow=1.
//   - FWFT=1: write 0xA5 into empty.
//     Required: next cycle rd_valid=1 and data_out=0xA5 with no read.
//     Then read: empty=1 and rd_valid=0 the following cycle.
//   - Thresholds AF=4, AE=1: fill 0->6.
//     Required: almost_empty 1 at counts 0,1 then 0; almost_full 1 from count 4 onward.
//   - Flush with write at count=4.
//     Required: count=0, empty=1, sticky flags cleared, the write discarded.
//   - Async rst_n pulse mid-cycle: outputs go to reset values before the next clk edge.

Source files
------------

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - parametrised single-clock FIFO, any DEPTH >= 2, registered or FWFT read
// Status flags are registered from the next count so they line up with the pointers.
module sync_fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         write,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         read,
  output logic [WIDTH-1:0]             data_out,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic AF_AT_ZERO = (AF_THRESH == 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             wr_ok;
  logic             rd_ok;
  logic [CW-1:0]    count_next;

  assign wr_ok      = write & ~full;
  assign rd_ok      = read & ~empty;
  assign count_next = count + CW'(wr_ok) - CW'(rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= AF_AT_ZERO;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= AF_AT_ZERO;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      // Explicit wrap compare so non-power-of-2 depths work.
      if (wr_ok) head <= (head == LAST) ? '0 : head + AW'(1);
      if (rd_ok) tail <= (tail == LAST) ? '0 : tail + AW'(1);
      count        <= count_next;
      full         <= (count_next == CW'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= CW'(AF_THRESH));
      almost_empty <= (count_next <= CW'(AE_THRESH));
      if (write & full) overflow <= 1'b1;
      if (read & empty) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && wr_ok) mem[head] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Masked while empty so the output reads zero after reset/flush.
      assign data_out = empty ? '0 : mem[tail];
      assign rd_valid = ~empty;
    end else begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out <= '0;
          rd_valid <= 1'b0;
        end else if (flush) begin
          data_out <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_ok;
          if (rd_ok) data_out <= mem[tail];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - directed bench for sync_fifo_flex, registered and FWFT instances
module tb_sync_fifo_flex;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       write;
  logic       read;
  logic [7:0] data_in;

  logic [7:0] d0, d1;
  logic       v0, f0, e0, af0, ae0, ov0, un0;
  logic       v1, f1, e1, af1, ae1, ov1, un1;
  logic [2:0] c0, c1;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  logic [7:0] q[$];
  logic [7:0] exp5 [5];

  sync_fifo_flex #(.WIDTH(8), .DEPTH(6), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .flush(flush), .write(write), .data_in(data_in), .read(read),
    .data_out(d0), .rd_valid(v0), .full(f0), .empty(e0), .almost_full(af0),
    .almost_empty(ae0), .count(c0), .overflow(ov0), .underflow(un0)
  );

  sync_fifo_flex #(.WIDTH(8), .DEPTH(6), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .write(write), .data_in(data_in), .read(read),
    .data_out(d1), .rd_valid(v1), .full(f1), .empty(e1), .almost_full(af1),
    .almost_empty(ae1), .count(c1), .overflow(ov1), .underflow(un1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
    write = w; data_in = d; read = r; flush = f;
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; write = 1'b0; read = 1'b0; data_in = 8'h00;
    exp5 = '{8'h48, 8'h49, 8'h50, 8'h51, 8'h52};
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", e0, 1);
    check("rst_full", f0, 0);
    check("rst_ae", ae0, 1);
    check("rst_af", af0, 0);
    check("rst_count", c0, 0);
    check("rst_valid", v0, 0);
    check("rst_data", d0, 0);
    check("rst_ov_un", {ov0, un0}, 0);
    check("rst_fwft_valid", v1, 0);
    rst_n = 1'b1;

    // Fill 0x11..0x16, watching thresholds on the way up.
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
      check("fill_cnt", c0, k);
      check("fill_ae", ae0, (k <= 1));
      check("fill_af", af0, (k >= 4));
    end
    check("fill_full", f0, 1);
    check("fwft_head", d1, 8'h11);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("order_valid", v0, 1);
      check("order_data", d0, 8'(8'h10 + k));
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("order_idle_valid", v0, 0);
    check("order_hold", d0, 8'h16);
    check("order_empty", e0, 1);

    // Write+read on empty: write wins, read flagged.
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    check("empty_wr_cnt", c0, 1);
    check("empty_wr_un", un0, 1);
    check("empty_wr_valid", v0, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("flush1_cnt", c0, 0);
    check("flush1_un", un0, 0);

    // Wrap: 18 writes and 18 reads so both pointers wrap three times.
    for (int i = 0; i < 20; i++) begin
      logic w, r, wok, rok;
      logic [7:0] exp_d;
      w = (i < 18);
      r = (i >= 2);
      wok = w && (q.size() < 6);
      rok = r && (q.size() > 0);
      exp_d = 8'h00;
      if (rok) exp_d = q.pop_front();
      if (wok) q.push_back(8'(8'h20 + i));
      cyc(w, 8'(8'h20 + i), r, 1'b0);
      check("wrap_cnt", c0, q.size());
      check("wrap_valid", v0, rok);
      if (rok) check("wrap_data", d0, exp_d);
    end
    check("wrap_empty", e0, 1);

    // Steady state at count 3.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      check("sim3_cnt", c0, 3);
      check("sim3_valid", v0, 1);
      check("sim3_data", d0, (i < 3) ? 8'(8'h31 + i) : 8'(8'h40 + i - 3));
    end

    // Write+read on full: read wins, pushed word dropped.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    check("full_pre", f0, 1);
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    check("full_wr_cnt", c0, 5);
    check("full_wr_ov", ov0, 1);
    check("full_wr_data", d0, 8'h47);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("full_drain", d0, exp5[i]);
    end
    check("full_drain_empty", e0, 1);
    check("ov_sticky", ov0, 1);

    // Flush with a simultaneous write at count 4.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("underflow_set", un0, 1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    check("pre_flush_cnt", c0, 4);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    check("flush_cnt", c0, 0);
    check("flush_empty", e0, 1);
    check("flush_sticky", {ov0, un0}, 0);
    check("flush_out", {v0, d0}, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("flush_discard", c0, 0);

    // FWFT: word visible one cycle after write without a read.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    check("fwft_valid", v1, 1);
    check("fwft_data", d1, 8'hA5);
    check("reg_no_valid", v0, 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_pop_empty", e1, 1);
    check("fwft_pop_valid", v1, 0);
    check("reg_pop_data", {v0, d0}, {1'b1, 8'hA5});

    // Asynchronous reset pulse between clock edges.
    cyc(1'b1, 8'h71, 1'b0, 1'b0);
    cyc(1'b1, 8'h72, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst", {v0, d0, 5'(c0)}, {1'b1, 8'h71, 5'd1});
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", c0, 0);
    check("arst_flags", {e0, f0, ae0, af0}, 4'b1010);
    check("arst_out", {v0, d0}, 0);
    check("arst_fwft", {v1, d1}, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst", {e0, 5'(c0)}, {1'b1, 5'd0});

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
